linemem_ntap: RTL and testbench
===============================

Name: linemem_ntap

Overview:
- Parametrised successor of the line memory. Delays the incoming video stream by 0..NTAP-1 lines and presents all taps column-aligned, so a downstream vertical filter or window generator can consume them directly.
- Sits between the signal generator (hd/de/d) and any vertical processing stage.
- Adds over the single-tap line memory:
  - configurable width, depth and tap count;
  - frame reset input;
  - per-tap valid flags;
  - top-edge replicate/zero mode;
  - overflow detection.

Parameters:
- DW, 8, pixel data width in bits.
- MAXW, 1024, maximum active pixels per line (RAM depth). AW = clog2(MAXW) is a derived localparam.
- NTAP, 3, number of output taps, legal range 2..8. Tap 0 is the current line; tap k is k lines earlier. Requires NTAP-1 line RAMs.

Ports:
- clk  in  1  system clock; all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- edge_mode  in  1  0 = invalid taps output zero; 1 = invalid taps replicate the oldest valid line. Sampled every cycle.
- vd  in  1  frame start pulse; clears line count and overflow flag.
- hd  in  1  line start pulse; clears column counter.
- de  in  1  data enable; d is valid when high.
- d  in  DW  input pixel.
- hdo  out  1  hd delayed by 2 cycles.
- deo  out  1  de delayed by 2 cycles.
- q  out  NTAP*DW  tap k on bits [k*DW +: DW].
- tap_valid  out  NTAP  bit k high when tap k holds real data for the current line.
- ovf  out  1  sticky: a line exceeded MAXW pixels.

Behaviour:
- Reset (synchronous, active-high):
  - hdo, deo, q, tap_valid, ovf = 0;
  - column counter, line counter, pipeline registers = 0;
  - RAM contents are not cleared; tap_valid masks stale data.
  - Reset asserted mid-line: hdo/deo/q are 0 on the following cycle and stay 0 until reset releases.
- Column counter:
  - hd=1 sets col=0 for the pixel accepted in the same cycle; hd+de together is legal, and that pixel is col 0.
  - Each de=1 cycle uses the current col, then col increments, saturating at MAXW.
- Line counter lcnt:
  - Range 0..NTAP-1, saturating.
  - On hd, increments if the previous line carried at least one de pixel.
  - vd=1 sets lcnt=0, has priority over a simultaneous hd, and clears ovf.
- Pipeline, fixed latency 2 cycles for all outputs:
  - Cycle t: de=1 at column c; all RAMs are read at address c.
  - Cycle t+1: RAM k read data is tap k+1. Cascade write at address c: RAM 0 <- d(t), RAM k <- RAM k-1 read data. Read-before-write is guaranteed because write address c trails read address c+1.
  - Cycle t+2: q, tap_valid, deo, hdo are registered out.
- Outputs:
  - tap_valid[k] = deo & (lcnt >= k), with lcnt sampled at the pixel's input cycle.
  - Tap 0 is valid whenever deo=1.
  - Invalid tap k: edge_mode=0 gives 0; edge_mode=1 gives the value of tap lcnt (oldest valid).
  - deo=0: q = 0 and tap_valid = 0.
- Overflow:
  - A de pixel with col >= MAXW is not written to any RAM.
  - Its taps 1..NTAP-1 output 0 with tap_valid 0; tap 0 passes through normally.
  - ovf is set at t+2 and held until vd or reset.
- Line length changes between lines: columns beyond the previous line's length read stale RAM data. This is the caller's responsibility; the block does not flag it.
- hd with no following de: no RAM writes; lcnt is unchanged on the next hd.

Test Plan:
1. Reset/latency: reset=1 for 5 cycles, then hd pulse with de high for 4 pixels (d=10,11,12,13). Required: hdo 2 cycles after hd; deo high 2 cycles after de for 4 cycles; q tap0 = 10,11,12,13; tap_valid = 3'b001; all outputs 0 during reset.
2. Vertical ramp, NTAP=3, line width 16: line n has all pixels = n, for lines 0..4. Required:
   - line 2 outputs tap0=2, tap1=1, tap2=0, tap_valid=3'b111;
   - line 4 outputs 4,3,2.
3. Edge mode, same stimulus as 2:
   - edge_mode=1: line 1 gives tap2 = 0 (replicate of tap1's line 0 value), tap_valid = 3'b011;
   - edge_mode=0: line 0 gives tap1 = tap2 = 0, tap_valid = 3'b001.
4. Overflow, MAXW=8: a line of 10 pixels (d=col). Required:
   - pixels 8,9 have tap1 = 0 and tap_valid[1] = 0;
   - ovf rises 2 cycles after pixel 8 and stays high;
   - the next vd clears ovf and lcnt, so the following line gives tap_valid = 3'b001.
5. Simultaneous events: vd, hd and de in the same cycle with d=0x55. Required: the pixel is col 0, lcnt = 0, and tap_valid = 3'b001 two cycles later.
6. Reset mid-line: assert reset at pixel 5 of a 16-pixel line. Required:
   - deo = 0 from the next cycle onward;
   - after release, the first line has tap_valid = 3'b001 (lcnt was cleared).

Source files
------------

// File: rtl/linemem_ntap.sv
// N-tap line memory: delays the video stream by 0..NTAP-1 lines and presents
// all taps column-aligned with per-tap valid flags, top-edge handling and overflow flag.
module linemem_ntap #(
  parameter int DW   = 8,
  parameter int MAXW = 1024,
  parameter int NTAP = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 edge_mode,
  input  logic                 vd,
  input  logic                 hd,
  input  logic                 de,
  input  logic [DW-1:0]        d,
  output logic                 hdo,
  output logic                 deo,
  output logic [NTAP*DW-1:0]   q,
  output logic [NTAP-1:0]      tap_valid,
  output logic                 ovf
);

  localparam int AW = $clog2(MAXW);
  localparam int CW = $clog2(MAXW + 1);
  localparam int LW = $clog2(NTAP);
  localparam logic [CW-1:0] COL_MAX = CW'(MAXW);
  localparam logic [LW-1:0] LMAX    = LW'(NTAP - 1);

  // Stream interface: no backpressure. de qualifies d for exactly one cycle;
  // every input cycle reappears on hdo/deo/q/tap_valid exactly 2 cycles later.

  logic [CW-1:0] col, col_cur;
  logic [LW-1:0] lcnt, lcnt_cur;
  logic          line_has_de;
  logic          in_range;
  logic [AW-1:0] addr;

  // Counter values that apply to the pixel arriving this cycle, so hd/vd
  // coinciding with de affect that same pixel.
  assign col_cur  = hd ? '0 : col;
  assign in_range = (col_cur < COL_MAX);
  assign addr     = col_cur[AW-1:0];

  always_comb begin
    lcnt_cur = lcnt;
    if (vd)
      lcnt_cur = '0;
    else if (hd && line_has_de && (lcnt != LMAX))
      lcnt_cur = lcnt + LW'(1);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      col         <= '0;
      lcnt        <= '0;
      line_has_de <= 1'b0;
    end else begin
      lcnt <= lcnt_cur;
      if (de && in_range)
        col <= col_cur + CW'(1);
      else
        col <= col_cur;
      if (vd || hd)
        line_has_de <= de;
      else if (de)
        line_has_de <= 1'b1;
    end
  end

  logic          s1_de, s1_hd, s1_inr;
  logic [DW-1:0] s1_d;
  logic [AW-1:0] s1_addr;
  logic [LW-1:0] s1_lcnt;

  always_ff @(posedge clk) begin
    if (reset) begin
      s1_de   <= 1'b0;
      s1_hd   <= 1'b0;
      s1_inr  <= 1'b0;
      s1_d    <= '0;
      s1_addr <= '0;
      s1_lcnt <= '0;
    end else begin
      s1_de   <= de;
      s1_hd   <= hd;
      s1_inr  <= in_range;
      s1_d    <= d;
      s1_addr <= addr;
      s1_lcnt <= lcnt_cur;
    end
  end

  // taps[k] is the stage-1 view of tap k: tap 0 is the pixel itself, tap k
  // is the read data of RAM k-1, which also feeds the write of RAM k.
  logic [NTAP*DW-1:0] taps;
  logic               wr_en;

  assign taps[DW-1:0] = s1_d;
  assign wr_en        = s1_de & s1_inr;

  for (genvar r = 0; r < NTAP - 1; r++) begin : g_ram
    logic [DW-1:0] mem [MAXW];
    logic [DW-1:0] rd_q;

    always_ff @(posedge clk) begin
      if (wr_en)
        mem[s1_addr] <= taps[r*DW +: DW];
    end

    always_ff @(posedge clk) begin
      if (reset)
        rd_q <= '0;
      else if (de)
        rd_q <= mem[addr];
    end

    assign taps[(r+1)*DW +: DW] = rd_q;
  end

  logic [NTAP*DW-1:0] q_next;
  logic [NTAP-1:0]    tv_next;
  logic [DW-1:0]      oldest;

  always_comb begin
    q_next  = '0;
    tv_next = '0;
    oldest  = taps[int'(s1_lcnt)*DW +: DW];
    if (s1_de) begin
      q_next[DW-1:0] = s1_d;
      tv_next[0]     = 1'b1;
      for (int k = 1; k < NTAP; k++) begin
        if (s1_inr && (int'(s1_lcnt) >= k)) begin
          tv_next[k]         = 1'b1;
          q_next[k*DW +: DW] = taps[k*DW +: DW];
        end else if (s1_inr && edge_mode) begin
          q_next[k*DW +: DW] = oldest;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hdo       <= 1'b0;
      deo       <= 1'b0;
      q         <= '0;
      tap_valid <= '0;
      ovf       <= 1'b0;
    end else begin
      hdo       <= s1_hd;
      deo       <= s1_de;
      q         <= q_next;
      tap_valid <= tv_next;
      if (vd)
        ovf <= 1'b0;
      else if (s1_de && !s1_inr)
        ovf <= 1'b1;
    end
  end

endmodule

// File: tb/tb_linemem_ntap.sv
// Self-checking bench for linemem_ntap: per-column line history model feeding
// an expected-pixel queue, popped by a monitor whenever deo is high.
module tb_linemem_ntap;

  localparam int DW   = 8;
  localparam int MAXW = 16;
  localparam int NTAP = 3;
  localparam int W    = 1 + NTAP + NTAP*DW;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              edge_mode = 1'b0;
  logic              vd = 1'b0, hd = 1'b0, de = 1'b0;
  logic [DW-1:0]     d = '0;
  logic              hdo, deo, ovf;
  logic [NTAP*DW-1:0] q;
  logic [NTAP-1:0]   tap_valid;

  always #5 clk = ~clk;

  linemem_ntap #(.DW(DW), .MAXW(MAXW), .NTAP(NTAP)) dut (
    .clk(clk), .reset(reset), .edge_mode(edge_mode), .vd(vd), .hd(hd), .de(de),
    .d(d), .hdo(hdo), .deo(deo), .q(q), .tap_valid(tap_valid), .ovf(ovf)
  );

  int errors = 0;
  int checks = 0;
  logic [W-1:0]  exp_q[$];
  logic [DW-1:0] hist [MAXW][$];
  int m_lcnt = 0, m_col = 0;
  bit m_had = 0, m_ovf = 0;
  bit mon_en = 0;
  logic hd1 = 0, hd2 = 0, de1 = 0, de2 = 0;

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  // Reference: lines since frame start, and for each column the values
  // written there by previous lines, newest first.
  task automatic model(input bit v, input bit h, input bit e, input logic [DW-1:0] dv, input bit rst);
    logic [DW-1:0]      tp [NTAP];
    logic [NTAP-1:0]    tv;
    logic [NTAP*DW-1:0] qv;
    if (rst) begin
      m_lcnt = 0; m_had = 0; m_col = 0; m_ovf = 0;
      return;
    end
    if (v) begin
      m_lcnt = 0; m_had = 0; m_ovf = 0;
    end else if (h) begin
      if (m_had && m_lcnt < NTAP-1) m_lcnt++;
      m_had = 0;
    end
    if (h) m_col = 0;
    if (e) begin
      tv = '0; qv = '0;
      tv[0] = 1'b1; qv[DW-1:0] = dv;
      if (m_col < MAXW) begin
        tp[0] = dv;
        for (int k = 1; k < NTAP; k++)
          tp[k] = (hist[m_col].size() >= k) ? hist[m_col][k-1] : '0;
        for (int k = 1; k < NTAP; k++) begin
          if (k <= m_lcnt) begin
            tv[k] = 1'b1; qv[k*DW +: DW] = tp[k];
          end else if (edge_mode) begin
            qv[k*DW +: DW] = tp[m_lcnt];
          end
        end
        hist[m_col].push_front(dv);
        if (hist[m_col].size() > NTAP-1) void'(hist[m_col].pop_back());
        m_col++;
      end else begin
        m_ovf = 1;
      end
      exp_q.push_back({m_ovf, tv, qv});
      m_had = 1;
    end
  endtask

  task automatic cyc(input bit v, input bit h, input bit e, input logic [DW-1:0] dv, input bit rst = 0);
    @(posedge clk); #1;
    reset = rst; vd = v; hd = h; de = e; d = dv;
    model(v, h, e, dv, rst);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, '0);
  endtask

  // kind 0: constant val, 1: d = column, 2: random
  task automatic line(input int w, input int kind, input int val, input bit hd_de = 0);
    logic [DW-1:0] dv;
    if (!hd_de) cyc(0, 1, 0, '0);
    for (int i = 0; i < w; i++) begin
      dv = (kind == 0) ? DW'(val) : (kind == 1) ? DW'(i) : DW'($urandom_range(0, 255));
      cyc(0, hd_de && (i == 0), 1, dv);
    end
    idle(3);
  endtask

  always @(posedge clk) begin
    hd1 <= reset ? 1'b0 : hd;
    hd2 <= reset ? 1'b0 : hd1;
    de1 <= reset ? 1'b0 : de;
    de2 <= reset ? 1'b0 : de1;
  end

  always @(negedge clk) begin
    logic [W-1:0] e;
    if (mon_en) begin
      check_bit("hdo", hdo, hd2);
      check_bit("deo", deo, de2);
      if (deo) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_pixel: got q=%h tv=%b expected none", q, tap_valid);
        end else begin
          e = exp_q.pop_front();
          check("pixel", {ovf, tap_valid, q}, e);
        end
      end else begin
        check("idle_out", W'({tap_valid, q}), '0);
      end
    end
  end

  initial begin
    int nl, w;
    repeat (2) @(posedge clk);
    mon_en = 1;
    repeat (3) cyc(0, 0, 0, '0, 1);
    @(negedge clk);
    check_bit("reset_ovf", ovf, 1'b0);

    // latency after reset
    cyc(0, 1, 0, '0);
    for (int i = 0; i < 4; i++) cyc(0, 0, 1, DW'(10 + i));
    idle(4);

    // vertical ramp, zero edge mode then replicate
    for (int m = 0; m < 2; m++) begin
      edge_mode = m[0];
      idle(2);
      cyc(1, 0, 0, '0);
      idle(2);
      for (int n = 0; n < 5; n++) line(16, 0, n);
    end
    edge_mode = 0;

    // overflow
    idle(2);
    cyc(1, 0, 0, '0);
    line(16, 2, 0);
    line(20, 1, 0);
    @(negedge clk);
    check_bit("ovf_set", ovf, 1'b1);
    idle(3);
    @(negedge clk);
    check_bit("ovf_sticky", ovf, 1'b1);
    cyc(1, 0, 0, '0);
    idle(2);
    @(negedge clk);
    check_bit("ovf_clear", ovf, 1'b0);
    line(16, 2, 0);

    // vd, hd and de together
    idle(2);
    cyc(1, 1, 1, 8'h55);
    for (int i = 1; i < 16; i++) cyc(0, 0, 1, DW'($urandom_range(0, 255)));
    idle(3);
    line(16, 2, 0);

    // reset mid-line at pixel 5
    cyc(0, 1, 0, '0);
    for (int i = 0; i < 5; i++) cyc(0, 0, 1, DW'(i + 100));
    cyc(0, 0, 1, 8'd105, 1);
    cyc(0, 0, 1, 8'd106, 1);
    exp_q.delete();
    cyc(0, 0, 0, '0, 1);
    idle(2);
    for (int n = 0; n < 3; n++) line(16, 2, 0);

    // random frames
    for (int f = 0; f < 8; f++) begin
      edge_mode = 1'($urandom_range(0, 1));
      idle(2);
      cyc(1, 0, 0, '0);
      idle(1);
      nl = $urandom_range(1, 6);
      w  = $urandom_range(8, 16);
      for (int n = 0; n < nl; n++) line(w, 2, 0, 1'($urandom_range(0, 1)));
    end

    for (int i = 0; i < 20 && exp_q.size() != 0; i++) @(negedge clk);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending pixels expected 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
